// File: rtl/excl_grant_arbiter_if.sv
// Request/burst handshake bundle between requesters and the exclusive-grant arbiter.
// The master side drives requests and downstream readiness; the slave side is the arbiter.
interface excl_grant_arbiter_if #(
   parameter int LENW = 2
);
   logic [2:0]        req;
   logic [3*LENW-1:0] len;
   logic              out_ready;
   logic [2:0]        gnt;
   logic [1:0]        sel;
   logic              out_valid;
   logic              out_last;
   logic [LENW-1:0]   beat;

   modport master (
      output req, len, out_ready,
      input  gnt, sel, out_valid, out_last, beat
   );

   modport slave (
      input  req, len, out_ready,
      output gnt, sel, out_valid, out_last, beat
   );
endinterface

// File: rtl/excl_grant_arbiter.sv
// Three-way round-robin arbiter granting one requester an exclusive burst of len+1 beats.
// All outputs are registered; bursts run to completion with the length captured at grant time.
module excl_grant_arbiter #(
   parameter int LENW = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   excl_grant_arbiter_if.slave  bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [2:0]      gnt_q, gnt_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      ptr_q, ptr_d;
   logic            vld_q, vld_d;
   logic            last_q, last_d;
   logic [LENW-1:0] beat_q, beat_d;
   logic [LENW-1:0] len_q, len_d;

   logic [1:0]      cand1, cand2, win;
   logic [LENW-1:0] win_len;
   logic [LENW-1:0] beat_inc;

   function automatic logic [1:0] inc_mod3(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Priority walks ptr+1, ptr+2, then ptr itself, so the last grantee goes to the back.
   always_comb begin
      cand1 = inc_mod3(ptr_q);
      cand2 = inc_mod3(cand1);
      if (bus.req[cand1])
         win = cand1;
      else if (bus.req[cand2])
         win = cand2;
      else
         win = ptr_q;
      case (win)
         2'd1:    win_len = bus.len[LENW +: LENW];
         2'd2:    win_len = bus.len[2*LENW +: LENW];
         default: win_len = bus.len[0 +: LENW];
      endcase
   end

   assign beat_inc = beat_q + LENW'(1);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      vld_d   = vld_q;
      last_d  = last_q;
      beat_d  = beat_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = BUSY;
               gnt_d   = 3'b001 << win;
               sel_d   = win;
               len_d   = win_len;
               beat_d  = '0;
               vld_d   = 1'b1;
               last_d  = (win_len == '0);
            end
         end
         BUSY: begin
            if (bus.out_ready) begin
               if (last_q) begin
                  state_d = IDLE;
                  ptr_d   = sel_q;
                  gnt_d   = '0;
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
                  beat_d  = '0;
               end else begin
                  // out_last is registered, so it is precomputed against the next beat index.
                  beat_d = beat_inc;
                  last_d = (beat_inc == len_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= 2'd2;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         beat_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.sel       = sel_q;
   assign bus.out_valid = vld_q;
   assign bus.out_last  = last_q;
   assign bus.beat      = beat_q;

endmodule

// File: tb/tb_excl_grant_arbiter.sv
// Directed bench for excl_grant_arbiter: scenario tasks compare {gnt,sel,out_valid,out_last,beat}
// after each edge, and a per-cycle monitor checks the grant/valid/select invariants.
module tb_excl_grant_arbiter;

   localparam int LENW = 2;

   logic clock;
   logic reset_n;
   int   n_total;
   int   n_pass;

   excl_grant_arbiter_if #(.LENW(LENW)) bus ();

   excl_grant_arbiter #(.LENW(LENW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Invariants sampled on every falling edge of every scenario.
   always @(negedge clock) begin
      n_total = n_total + 1;
      if (!$onehot0(bus.gnt) || ((bus.gnt != 3'b000) !== bus.out_valid) ||
          (bus.out_valid && (bus.gnt !== (3'b001 << bus.sel)))) begin
         $display("FAIL invariant t=%0t gnt=%b sel=%0d out_valid=%b", $time, bus.gnt, bus.sel, bus.out_valid);
      end else begin
         n_pass = n_pass + 1;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Observed vector layout: {gnt[2:0], sel[1:0], out_valid, out_last, beat[1:0]}.
   function automatic logic [8:0] obs();
      return {bus.gnt, bus.sel, bus.out_valid, bus.out_last, bus.beat};
   endfunction

   task automatic do_reset();
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      n_total = n_total + 1;
      if (obs() !== 9'b000_00_0_0_00)
         $display("FAIL async_reset actual=%b required=%b", obs(), 9'b000_00_0_0_00);
      else
         n_pass = n_pass + 1;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [2:0] exp_gnt [7];
      logic [1:0] exp_sel [7];
      logic [8:0] e;
      exp_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      exp_sel = '{2'd0,   2'd0,   2'd1,   2'd1,   2'd2,   2'd2,   2'd0};
      bus.req       = 3'b111;
      bus.len       = '0;
      bus.out_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step();
         e = {exp_gnt[i], exp_sel[i], exp_gnt[i] != 3'b000, exp_gnt[i] != 3'b000, 2'd0};
         n_total = n_total + 1;
         if (obs() !== e)
            $display("FAIL rr_single_beat[%0d] actual=%b required=%b", i, obs(), e);
         else
            n_pass = n_pass + 1;
      end
      bus.req = 3'b000;
      step();
      n_total = n_total + 1;
      if (obs() !== 9'b000_00_0_0_00)
         $display("FAIL rr_idle_end actual=%b required=%b", obs(), 9'b000_00_0_0_00);
      else
         n_pass = n_pass + 1;
   endtask

   task automatic test_backpressure();
      logic       rdy [5];
      logic [8:0] exp [5];
      rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      // Values after each edge; the valid cycles present beats 0,1,1,2,3.
      exp = '{9'b001_00_1_0_01, 9'b001_00_1_0_01, 9'b001_00_1_0_10,
              9'b001_00_1_1_11, 9'b000_00_0_0_00};
      bus.req = 3'b001;
      bus.len = 6'b00_00_11;
      bus.out_ready = 1'b1;
      step();
      n_total = n_total + 1;
      if (obs() !== 9'b001_00_1_0_00)
         $display("FAIL bp_grant actual=%b required=%b", obs(), 9'b001_00_1_0_00);
      else
         n_pass = n_pass + 1;
      bus.req = 3'b000;
      for (int i = 0; i < 5; i++) begin
         bus.out_ready = rdy[i];
         step();
         n_total = n_total + 1;
         if (obs() !== exp[i])
            $display("FAIL bp_beat[%0d] actual=%b required=%b", i, obs(), exp[i]);
         else
            n_pass = n_pass + 1;
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_ignore_changes();
      logic [8:0] exp [4];
      exp = '{9'b010_01_1_0_00, 9'b010_01_1_0_01, 9'b010_01_1_1_10, 9'b000_01_0_0_00};
      bus.req = 3'b010;
      bus.len = 6'b00_10_00;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 0) begin
            bus.req = 3'b000;
            bus.len = 6'b00_00_00;
         end
         n_total = n_total + 1;
         if (obs() !== exp[i])
            $display("FAIL ignore_changes[%0d] actual=%b required=%b", i, obs(), exp[i]);
         else
            n_pass = n_pass + 1;
      end
   endtask

   task automatic test_reset_mid_burst();
      bus.req = 3'b001;
      bus.len = 6'b00_00_11;
      bus.out_ready = 1'b1;
      step();
      step();
      n_total = n_total + 1;
      if (obs() !== 9'b001_00_1_0_01)
         $display("FAIL mid_burst_pre actual=%b required=%b", obs(), 9'b001_00_1_0_01);
      else
         n_pass = n_pass + 1;
      bus.req = 3'b111;
      bus.len = '0;
      do_reset();
      n_total = n_total + 1;
      if (obs() !== 9'b000_00_0_0_00)
         $display("FAIL mid_burst_held actual=%b required=%b", obs(), 9'b000_00_0_0_00);
      else
         n_pass = n_pass + 1;
      step();
      n_total = n_total + 1;
      if (obs() !== 9'b001_00_1_1_00)
         $display("FAIL post_reset_grant actual=%b required=%b", obs(), 9'b001_00_1_1_00);
      else
         n_pass = n_pass + 1;
      bus.req = 3'b000;
      step();
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_gnt [7];
      bus.req       = 3'b011;
      bus.len       = '0;
      bus.out_ready = 1'b1;
      do_reset();
      exp_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010};
      for (int i = 0; i < 7; i++) begin
         step();
         n_total = n_total + 1;
         if (bus.gnt !== exp_gnt[i] || bus.out_last !== (exp_gnt[i] != 3'b000))
            $display("FAIL alternate[%0d] actual gnt=%b last=%b required gnt=%b last=%b",
                     i, bus.gnt, bus.out_last, exp_gnt[i], exp_gnt[i] != 3'b000);
         else
            n_pass = n_pass + 1;
      end
      bus.req = 3'b000;
      step();
      step();
   endtask

   initial begin
      n_total       = 0;
      n_pass        = 0;
      reset_n       = 1'b0;
      bus.req       = 3'b000;
      bus.len       = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_backpressure();
      test_ignore_changes();
      test_reset_mid_burst();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/excl_grant_arbiter.md
EXCL_GRANT_ARBITER -- requirements
Module: excl_grant_arbiter

Interface
REQ-001 Parameter LENW, default 2: width of each burst-length field; a burst is len+1 beats, 1..2^LENW beats.
REQ-002 Port clock, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1: reset is asynchronous and active-low.
REQ-004 Port req, input, 3: per-requester request, bit i = requester i.
REQ-005 Port len, input, 3*LENW: per-requester burst length minus one; requester i uses len[i*LENW +: LENW].
REQ-006 Port out_ready, input, 1: downstream accepts the current beat.
REQ-007 Port gnt, output, 3: one-hot grant, or zero.
REQ-008 Port sel, output, 2: encoded index of the current grantee.
REQ-009 Port out_valid, output, 1: a beat is presented.
REQ-010 Port out_last, output, 1: the presented beat is the final beat of the burst.
REQ-011 Port beat, output, LENW: index of the presented beat, starting at 0.

Function
REQ-012 The block SHALL implement two states, IDLE and BUSY; all outputs SHALL be registered.
REQ-013 In IDLE with req != 0, the block SHALL pick a winner by round-robin; priority order is ptr+1, ptr+2, ptr (mod 3), where ptr is the index of the last completed grantee.
REQ-014 On that edge the block SHALL:
- enter BUSY;
- set gnt to the one-hot of the winner and sel to its index;
- capture the winner's len into an internal register;
- clear beat to 0.
Grant latency is therefore one cycle from sampled req.
REQ-015 In IDLE with req == 0, state and outputs SHALL hold; gnt=0 and out_valid=0.
REQ-016 In BUSY:
- out_valid SHALL be 1;
- a beat transfers on each edge where out_valid & out_ready;
- each transfer SHALL increment beat by 1;
- when out_ready=0, beat SHALL hold.
REQ-017 out_last SHALL equal 1 exactly when beat equals the captured len during BUSY, and 0 otherwise.
REQ-018 On a transfer with out_last=1, the block SHALL:
- set ptr to sel;
- clear gnt, out_valid and beat;
- return to IDLE.
At least one IDLE cycle therefore separates consecutive grants.
REQ-019 Changes to req or len during BUSY SHALL be ignored; the burst completes with its captured length, even if the grantee drops req.
REQ-020 Invariants:
- gnt SHALL never have more than one bit set;
- gnt != 0 iff out_valid=1;
- gnt SHALL be the one-hot encoding of sel whenever out_valid=1.
REQ-021 beat SHALL never wrap: with captured len = 2^LENW-1, the burst ends at beat = 2^LENW-1.
REQ-022 A requester held continuously SHALL wait at most two other bursts before its grant (no starvation).

Reset
REQ-023 While reset_n=0, independent of clock:
- state=IDLE, gnt=0, sel=0, out_valid=0, out_last=0, beat=0;
- ptr=2, so requester 0 has highest priority first.
REQ-024 Assertion of reset_n mid-burst SHALL abort the burst immediately; no beat SHALL be presented until a new arbitration after release.
REQ-025 The first arbitration after release SHALL occur on the first rising edge with reset_n=1.

Verification
REQ-026 Release reset with req=3'b111, len=0 for all, out_ready=1 -> gnt sequence 001, 0, 010, 0, 100, 0, 001, each grant 1 cycle with out_last=1, beat=0.
REQ-027 req=3'b001, len0=3, out_ready per valid cycle 1,0,1,1,1 -> 5 valid cycles with beat 0,1,1,2,3; out_last=1 only on the beat=3 cycle; then IDLE.
REQ-028 req=3'b010, len1=2; drop req and change len1 to 0 after the first beat -> burst still completes 3 beats with sel=1.
REQ-029 Drive reset_n=0 mid-burst (beat=1), then release with req=3'b111 -> gnt=0 and out_valid=0 asynchronously; the first post-reset grant is 001.
REQ-030 req=3'b011 held continuously, len=0, out_ready=1 -> grants alternate 001, 010, 001, 010; a bench checker SHALL assert REQ-020 on every cycle of every scenario.
